// File: rtl/dac_spi_tx.sv
// dac_spi_tx: valid/ready fed SPI transmitter for a 4-channel 12-bit serial DAC.
// Each accepted sample becomes {8'h00, cmd, addr, data, 4'h0}, shifted MSB first; all outputs registered.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [3:0]  DAC_CMD = 4'b0011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [11:0] sample_data,
  input  logic [3:0]  sample_addr,
  output logic        dac_cs_n,
  output logic        sck,
  output logic        mosi,
  output logic        dac_clr_n,
  output logic        done
);
  localparam int unsigned  CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_q;
  logic [31:0]   frame_q;
  logic [4:0]    bit_q;
  logic [CW-1:0] div_q;
  logic          ready_q, cs_n_q, sck_q, mosi_q, clr_n_q, done_q;

  logic          accept;
  logic          phase_end;
  logic [31:0]   frame_in;

  assign accept    = sample_valid & ready_q;
  assign phase_end = (div_q == {CW{1'b0}});
  assign frame_in  = {8'h00, DAC_CMD, sample_addr, sample_data, 4'h0};

  // Frame sequencer: every phase lasts CLK_DIV cycles, div_q reloads at each phase boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= 32'h0000_0000;
      bit_q   <= 5'd0;
      div_q   <= {CW{1'b0}};
      ready_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      clr_n_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clr_n_q <= 1'b1;
      done_q  <= 1'b0;
      if (!phase_end) begin
        div_q <= div_q - {{(CW-1){1'b0}}, 1'b1};
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SETUP;
            frame_q <= frame_in;
            bit_q   <= 5'd31;
            div_q   <= DIV_LOAD;
            ready_q <= 1'b0;
            cs_n_q  <= 1'b0;
            mosi_q  <= frame_in[31];
          end else begin
            ready_q <= 1'b1;
          end
        end
        SETUP: begin
          if (phase_end) begin
            state_q <= SHIFT;
            div_q   <= DIV_LOAD;
            sck_q   <= 1'b1;
          end
        end
        SHIFT: begin
          if (phase_end) begin
            div_q <= DIV_LOAD;
            if (sck_q) begin
              // Data moves on the falling edge so it is settled before the DAC's rising-edge sample.
              sck_q <= 1'b0;
              if (bit_q != 5'd0) begin
                mosi_q  <= frame_q[30];
                frame_q <= {frame_q[30:0], 1'b0};
              end
            end else if (bit_q == 5'd0) begin
              state_q <= HOLD;
            end else begin
              bit_q <= bit_q - 5'd1;
              sck_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            state_q <= GAP;
            div_q   <= DIV_LOAD;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          cs_n_q  <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign dac_cs_n     = cs_n_q;
  assign sck          = sck_q;
  assign mosi         = mosi_q;
  assign dac_clr_n    = clr_n_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: two transmitters (CLK_DIV=2 and CLK_DIV=1) driven by randomized samples;
// an SPI-slave monitor rebuilds each frame and checks it against a scoreboard queue.
module tb_dac_spi_tx;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic        sv[2];
  logic [11:0] sd[2];
  logic [3:0]  sa[2];
  logic        sr[2], cs[2], sck[2], mosi[2], clr[2], dn[2];

  typedef struct {
    int          k;
    logic [31:0] f;
  } exp_t;
  exp_t exp_q[$];

  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_done[2], exp_done[2], low[2], rises[2];
  logic [31:0] sh[2];
  logic pcs[2], psck[2], pmosi[2];
  logic pres;
  time last_acc[2];

  dac_spi_tx #(.CLK_DIV(2), .DAC_CMD(4'b0011)) u_dac0 (
    .clock(clock), .reset(reset), .sample_valid(sv[0]), .sample_ready(sr[0]),
    .sample_data(sd[0]), .sample_addr(sa[0]), .dac_cs_n(cs[0]), .sck(sck[0]),
    .mosi(mosi[0]), .dac_clr_n(clr[0]), .done(dn[0]));

  dac_spi_tx #(.CLK_DIV(1), .DAC_CMD(4'b0011)) u_dac1 (
    .clock(clock), .reset(reset), .sample_valid(sv[1]), .sample_ready(sr[1]),
    .sample_data(sd[1]), .sample_addr(sa[1]), .dac_cs_n(cs[1]), .sck(sck[1]),
    .mosi(mosi[1]), .dac_clr_n(clr[1]), .done(dn[1]));

  always #5 clock = ~clock;

  function automatic int cdv(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Reference frame: command in bits 23:20, channel in 19:16, code in 15:4.
  function automatic logic [31:0] ref_frame(logic [3:0] a, logic [11:0] d);
    return 32'(3 * (1 << 20) + int'(a) * (1 << 16) + int'(d) * 16);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: protocol violation at %0t", name, $time);
  endtask

  // Monitor: SPI slave plus protocol checker for both instances.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset || pres) begin
        low[k]   = 0;
        rises[k] = 0;
        sh[k]    = 32'h0;
        if (reset) exp_q.delete();
      end else if (!cs[k]) begin
        low[k]++;
        if (dn[k]) fail("done_while_cs_low");
        if (sck[k] && psck[k] && mosi[k] !== pmosi[k]) fail("mosi_changed_sck_high");
        if (sck[k] && !psck[k]) begin
          rises[k]++;
          sh[k] = {sh[k][30:0], mosi[k]};
          if (rises[k] == 1) chk("first_rise_cycle", 32'(low[k]), 32'(cdv(k) + 1));
        end
      end else begin
        if (sck[k] !== 1'b0) fail("sck_high_while_cs_high");
        if (!pcs[k]) begin
          chk("sck_rises", 32'(rises[k]), 32'd32);
          chk("cs_low_cycles", 32'(low[k]), 32'(66 * cdv(k)));
          chk("done_at_cs_rise", 32'(dn[k]), 32'd1);
          if (exp_q.size() == 0) begin
            fail("unexpected_frame");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("frame_instance", 32'(k), 32'(e.k));
            chk("frame_data", sh[k], e.f);
          end
          low[k]   = 0;
          rises[k] = 0;
        end else if (dn[k]) begin
          fail("stray_done");
        end
      end
      if (dn[k] && !reset) n_done[k]++;
      pcs[k]   = cs[k];
      psck[k]  = sck[k];
      pmosi[k] = mosi[k];
    end
    pres = reset;
  end

  // Offer a sample, wait for the handshake, push the expected frame.
  task automatic send(int k, logic [3:0] a, logic [11:0] d, bit hold, bit scramble);
    int t;
    sv[k] = 1'b1;
    sa[k] = a;
    sd[k] = d;
    t = 0;
    while (sr[k] !== 1'b1 && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 1000) fail("accept_timeout");
    @(posedge clock);
    last_acc[k] = $time;
    exp_q.push_back('{k: k, f: ref_frame(a, d)});
    exp_done[k]++;
    #1;
    if (!hold) begin
      sv[k] = 1'b0;
      @(negedge clock);
      t = 0;
      while (scramble && sr[k] !== 1'b1 && t < 1000) begin
        sv[k] = 1'($urandom);
        sd[k] = 12'($urandom);
        sa[k] = 4'($urandom);
        @(negedge clock);
        t++;
      end
      sv[k] = 1'b0;
    end
  endtask

  task automatic wait_idle(int k);
    int t;
    t = 0;
    while (sr[k] !== 1'b1 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 2000) fail("idle_timeout");
  endtask

  task automatic chk_reset_outputs(int k);
    chk("rst_ready", 32'(sr[k]), 32'd0);
    chk("rst_cs_n", 32'(cs[k]), 32'd1);
    chk("rst_sck", 32'(sck[k]), 32'd0);
    chk("rst_mosi", 32'(mosi[k]), 32'd0);
    chk("rst_clr_n", 32'(clr[k]), 32'd0);
    chk("rst_done", 32'(dn[k]), 32'd0);
  endtask

  initial begin
    int t;
    time t_first;
    pres = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0; sd[k] = 12'h0; sa[k] = 4'h0;
      n_done[k] = 0; exp_done[k] = 0; low[k] = 0; rises[k] = 0;
      sh[k] = 32'h0; pcs[k] = 1'b1; psck[k] = 1'b0; pmosi[k] = 1'b0;
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) chk_reset_outputs(k);
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("clr_n_after_release", 32'(clr[k]), 32'd1);
      chk("ready_after_release", 32'(sr[k]), 32'd1);
    end
    @(negedge clock);

    send(0, 4'h0, 12'hABC, 1'b0, 1'b0);
    wait_idle(0);

    send(0, 4'h1, 12'h000, 1'b1, 1'b0);
    t_first = last_acc[0];
    send(0, 4'hF, 12'hFFF, 1'b0, 1'b0);
    chk("b2b_accept_spacing", 32'((last_acc[0] - t_first) / 10), 32'd135);
    wait_idle(0);

    send(0, 4'($urandom), 12'($urandom), 1'b0, 1'b1);
    wait_idle(0);

    send(0, 4'h5, 12'h5A5, 1'b0, 1'b0);
    t = 0;
    while (rises[0] < 10 && t < 1000) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (t >= 1000) fail("rise10_timeout");
    reset = 1'b1;
    exp_done[0]--;
    #1;
    chk_reset_outputs(0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("clr_n_after_midframe_reset", 32'(clr[0]), 32'd1);
    @(negedge clock);
    send(0, 4'h2, 12'h123, 1'b0, 1'b0);
    wait_idle(0);

    send(1, 4'h0, 12'hABC, 1'b0, 1'b0);
    wait_idle(1);

    for (int i = 0; i < 24; i++) begin
      int k;
      k = int'($urandom_range(1, 0));
      send(k, 4'($urandom), 12'($urandom), 1'b0, 1'($urandom));
      wait_idle(k);
    end

    repeat (4) @(negedge clock);
    for (int k = 0; k < 2; k++) chk("done_count", 32'(n_done[k]), 32'(exp_done[k]));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
